// File: rtl/regf_cmd_master_pkg.sv
// Shared definitions for the GPIO command-word link between the command master and the register file.
package regf_cmd_master_pkg;

  localparam int STROBE_BIT = 23;
  localparam int RD_EN_BIT  = 16;
  localparam int LOG_EN_BIT = 0;

  localparam logic [7:0] CMD_CFG_01  = 8'h01;
  localparam logic [7:0] CMD_CFG_02  = 8'h02;
  localparam logic [7:0] CMD_SIGMA   = 8'h03;
  localparam logic [7:0] CMD_CFG_04  = 8'h04;
  localparam logic [7:0] CMD_CFG_06  = 8'h06;
  localparam logic [7:0] CMD_RAM_RD  = 8'h07;
  localparam logic [7:0] CMD_BER_LOG = 8'h08;
  localparam logic [7:0] CMD_BER_RD  = 8'h09;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'b00,
    OP_RAM_RD   = 2'b01,
    OP_SNAPSHOT = 2'b10,
    OP_ILLEGAL  = 2'b11
  } req_op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STROBE = 3'd1,
    S_SETTLE = 3'd2,
    S_GAP    = 3'd3,
    S_RSP    = 3'd4
  } state_e;

  // Snapshot step sequence; steps RD_FIRST..RD_LAST read counter words idx 0..7.
  localparam logic [3:0] SNAP_STEP_CLR_RAM = 4'd0;
  localparam logic [3:0] SNAP_STEP_LATCH   = 4'd1;
  localparam logic [3:0] SNAP_STEP_UNLATCH = 4'd2;
  localparam logic [3:0] SNAP_STEP_RD_FIRST = 4'd3;
  localparam logic [3:0] SNAP_STEP_RD_LAST  = 4'd10;
  localparam logic [3:0] SNAP_STEP_RELEASE  = 4'd11;

  localparam int IDX_ERR_I_LO = 0;
  localparam int IDX_ERR_I_HI = 1;
  localparam int IDX_BIT_I_LO = 2;
  localparam int IDX_BIT_I_HI = 3;
  localparam int IDX_ERR_Q_LO = 4;
  localparam int IDX_ERR_Q_HI = 5;
  localparam int IDX_BIT_Q_LO = 6;
  localparam int IDX_BIT_Q_HI = 7;

  function automatic logic [31:0] cmd_word(input logic [7:0] cmd, input logic strobe,
                                           input logic [22:0] payload);
    return {cmd, strobe, payload};
  endfunction

endpackage

// File: rtl/regf_cmd_master.sv
// Command-word initiator into the register file: sequences strobe/settle/gap bus steps per request
// and returns RAM read data or atomically updated 64-bit BER counter snapshots.
module regf_cmd_master
  import regf_cmd_master_pkg::*;
#(
  parameter int NBT_GPIOS          = 32,
  parameter int NBT_COUNT_BITS_ERR = 64,
  parameter int HOLD_CYCLES        = 2,
  parameter int SETTLE_CYCLES      = 1
) (
  input  logic                          clk,
  input  logic                          i_reset,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic [1:0]                    i_req_op,
  input  logic [7:0]                    i_req_cmd,
  input  logic [22:0]                   i_req_data,
  output logic [NBT_GPIOS-1:0]          o_gpio_to_regf,
  input  logic [NBT_GPIOS-1:0]          i_regf_to_gpio,
  output logic                          o_rsp_valid,
  output logic                          o_rsp_err,
  output logic [31:0]                   o_rsp_data,
  output logic [NBT_COUNT_BITS_ERR-1:0] o_accum_err_I,
  output logic [NBT_COUNT_BITS_ERR-1:0] o_accum_bit_I,
  output logic [NBT_COUNT_BITS_ERR-1:0] o_accum_err_Q,
  output logic [NBT_COUNT_BITS_ERR-1:0] o_accum_bit_Q,
  output logic                          o_busy
);

  if (NBT_GPIOS != 32) begin : g_bad_gpios
    $error("NBT_GPIOS must be 32");
  end
  if (NBT_COUNT_BITS_ERR != 64) begin : g_bad_count_bits
    $error("NBT_COUNT_BITS_ERR must be 64");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 1..15");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [3:0] HOLD_M1   = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] LATCH_M1  = 4'(((HOLD_CYCLES < 2) ? 2 : HOLD_CYCLES) - 1);
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  req_op_e          op_q, op_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [22:0]      data_q, data_d;
  logic [3:0]       step_q, step_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0][31:0] shadow_q, shadow_d;
  logic [31:0]      gpio_q, gpio_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [63:0]      accum_err_i_q, accum_err_i_d;
  logic [63:0]      accum_bit_i_q, accum_bit_i_d;
  logic [63:0]      accum_err_q_q, accum_err_q_d;
  logic [63:0]      accum_bit_q_q, accum_bit_q_d;
  logic [30:0]      step_bits;
  logic [2:0]       sample_idx;

  // Step ROM: {cmd[7:0], payload[22:0]} for a given op and step index.
  function automatic logic [30:0] step_cmd(input req_op_e op, input logic [7:0] cmd,
                                           input logic [22:0] data, input logic [3:0] step);
    logic [7:0]  c;
    logic [22:0] p;
    c = '0;
    p = '0;
    case (op)
      OP_WRITE: begin
        c = cmd;
        p = data;
      end
      OP_RAM_RD: begin
        c = CMD_RAM_RD;
        p[RD_EN_BIT] = 1'b1;
        p[14:0] = data[14:0];
      end
      OP_SNAPSHOT: begin
        if (step == SNAP_STEP_CLR_RAM) begin
          c = CMD_RAM_RD;
        end else if (step == SNAP_STEP_LATCH) begin
          c = CMD_BER_LOG;
          p[LOG_EN_BIT] = 1'b1;
        end else if (step == SNAP_STEP_UNLATCH) begin
          c = CMD_BER_LOG;
        end else if (step <= SNAP_STEP_RD_LAST) begin
          c = CMD_BER_RD;
          p[RD_EN_BIT] = 1'b1;
          p[2:0] = 3'(step - SNAP_STEP_RD_FIRST);
        end else begin
          c = CMD_BER_RD;
        end
      end
      default: ;
    endcase
    return {c, p};
  endfunction

  function automatic logic is_read(input req_op_e op, input logic [3:0] step);
    return (op == OP_RAM_RD) ||
           (op == OP_SNAPSHOT && step >= SNAP_STEP_RD_FIRST && step <= SNAP_STEP_RD_LAST);
  endfunction

  function automatic logic is_last(input req_op_e op, input logic [3:0] step);
    return (op != OP_SNAPSHOT) || (step == SNAP_STEP_RELEASE);
  endfunction

  // The latch step needs one cycle to arm logging and a second to capture the counters.
  function automatic logic [3:0] hold_m1(input req_op_e op, input logic [3:0] step);
    return (op == OP_SNAPSHOT && step == SNAP_STEP_LATCH) ? LATCH_M1 : HOLD_M1;
  endfunction

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cmd_d         = cmd_q;
    data_d        = data_q;
    step_d        = step_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    rsp_data_d    = rsp_data_q;
    accum_err_i_d = accum_err_i_q;
    accum_bit_i_d = accum_bit_i_q;
    accum_err_q_d = accum_err_q_q;
    accum_bit_q_d = accum_bit_q_q;
    sample_idx    = (op_q == OP_SNAPSHOT) ? 3'(step_q - SNAP_STEP_RD_FIRST) : 3'd0;

    case (state_q)
      S_IDLE: begin
        if (i_req_valid && ready_q) begin
          op_d    = req_op_e'(i_req_op);
          cmd_d   = i_req_cmd;
          data_d  = i_req_data;
          step_d  = '0;
          cnt_d   = hold_m1(op_d, 4'd0);
          state_d = (op_d == OP_ILLEGAL) ? S_RSP : S_STROBE;
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          if (is_read(op_q, step_q)) begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_M1;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          shadow_d[sample_idx] = i_regf_to_gpio;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_GAP: begin
        if (is_last(op_q, step_q)) begin
          state_d = S_RSP;
        end else begin
          step_d  = step_q + 4'd1;
          cnt_d   = hold_m1(op_q, step_d);
          state_d = S_STROBE;
        end
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are computed from the next state so they leave the flops aligned with it.
    step_bits = step_cmd(op_d, cmd_d, data_d, step_d);
    gpio_d    = '0;
    if (state_d == S_STROBE) begin
      gpio_d = cmd_word(step_bits[30:23], 1'b1, step_bits[22:0]);
    end else if (state_d == S_SETTLE || state_d == S_GAP) begin
      gpio_d = cmd_word(step_bits[30:23], 1'b0, step_bits[22:0]);
    end
    ready_d     = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_RSP);
    rsp_err_d   = rsp_valid_d && (op_d == OP_ILLEGAL);
    if (rsp_valid_d && op_d == OP_RAM_RD) begin
      rsp_data_d = shadow_q[0];
    end
    if (rsp_valid_d && op_d == OP_SNAPSHOT) begin
      accum_err_i_d = {shadow_q[IDX_ERR_I_HI], shadow_q[IDX_ERR_I_LO]};
      accum_bit_i_d = {shadow_q[IDX_BIT_I_HI], shadow_q[IDX_BIT_I_LO]};
      accum_err_q_d = {shadow_q[IDX_ERR_Q_HI], shadow_q[IDX_ERR_Q_LO]};
      accum_bit_q_d = {shadow_q[IDX_BIT_Q_HI], shadow_q[IDX_BIT_Q_LO]};
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      op_q          <= OP_WRITE;
      cmd_q         <= '0;
      data_q        <= '0;
      step_q        <= '0;
      cnt_q         <= '0;
      shadow_q      <= '0;
      gpio_q        <= '0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_data_q    <= '0;
      accum_err_i_q <= '0;
      accum_bit_i_q <= '0;
      accum_err_q_q <= '0;
      accum_bit_q_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cmd_q         <= cmd_d;
      data_q        <= data_d;
      step_q        <= step_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      gpio_q        <= gpio_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_data_q    <= rsp_data_d;
      accum_err_i_q <= accum_err_i_d;
      accum_bit_i_q <= accum_bit_i_d;
      accum_err_q_q <= accum_err_q_d;
      accum_bit_q_q <= accum_bit_q_d;
    end
  end

  assign o_req_ready    = ready_q;
  assign o_busy         = busy_q;
  assign o_gpio_to_regf = gpio_q;
  assign o_rsp_valid    = rsp_valid_q;
  assign o_rsp_err      = rsp_err_q;
  assign o_rsp_data     = rsp_data_q;
  assign o_accum_err_I  = accum_err_i_q;
  assign o_accum_bit_I  = accum_bit_i_q;
  assign o_accum_err_Q  = accum_err_q_q;
  assign o_accum_bit_Q  = accum_bit_q_q;

endmodule

// File: tb/tb_regf_cmd_master.sv
// Directed bench for regf_cmd_master paired with a behavioural register file + RAM model.
module tb_regf_cmd_master;

  logic        clk;
  logic        i_reset;
  logic        i_req_valid;
  logic [1:0]  i_req_op;
  logic [7:0]  i_req_cmd;
  logic [22:0] i_req_data;
  logic        o_req_ready;
  logic [31:0] o_gpio_to_regf;
  logic [31:0] regf_to_gpio;
  logic        o_rsp_valid;
  logic        o_rsp_err;
  logic [31:0] o_rsp_data;
  logic [63:0] o_accum_err_I, o_accum_bit_I, o_accum_err_Q, o_accum_bit_Q;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  int accept_cnt = 0;
  int rsp_cnt = 0;

  regf_cmd_master #(
    .NBT_GPIOS(32), .NBT_COUNT_BITS_ERR(64), .HOLD_CYCLES(2), .SETTLE_CYCLES(1)
  ) dut (
    .clk(clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_req_cmd(i_req_cmd), .i_req_data(i_req_data),
    .o_gpio_to_regf(o_gpio_to_regf), .i_regf_to_gpio(regf_to_gpio),
    .o_rsp_valid(o_rsp_valid), .o_rsp_err(o_rsp_err), .o_rsp_data(o_rsp_data),
    .o_accum_err_I(o_accum_err_I), .o_accum_bit_I(o_accum_bit_I),
    .o_accum_err_Q(o_accum_err_Q), .o_accum_bit_Q(o_accum_bit_Q),
    .o_busy(o_busy)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file + RAM model: decodes strobed words, latches counters on the second log cycle.
  logic [63:0] cnt_err_i = '0, cnt_bit_i = '0, cnt_err_q = '0, cnt_bit_q = '0;
  logic [63:0] lat_err_i = '0, lat_bit_i = '0, lat_err_q = '0, lat_bit_q = '0;
  logic [22:0] sigma_m = '0;
  logic        ram_sel_m = 1'b0;
  logic [14:0] ram_addr_m = '0;
  logic        cnt_sel_m = 1'b0;
  logic [2:0]  cnt_idx_m = '0;
  logic        log_arm_m = 1'b0;
  logic [31:0] lat_word;

  function automatic logic [31:0] ram_word(input logic [14:0] addr);
    return (addr == 15'h1234) ? 32'hDEADBEEF : {8'hA5, 9'h0, addr};
  endfunction

  always @(posedge clk) begin
    if (o_gpio_to_regf[23]) begin
      case (o_gpio_to_regf[31:24])
        8'h03: sigma_m <= o_gpio_to_regf[22:0];
        8'h07: begin
          ram_sel_m  <= o_gpio_to_regf[16];
          ram_addr_m <= o_gpio_to_regf[14:0];
        end
        8'h08: begin
          if (o_gpio_to_regf[0]) begin
            if (log_arm_m) begin
              lat_err_i <= cnt_err_i;
              lat_bit_i <= cnt_bit_i;
              lat_err_q <= cnt_err_q;
              lat_bit_q <= cnt_bit_q;
            end
            log_arm_m <= 1'b1;
          end else begin
            log_arm_m <= 1'b0;
          end
        end
        8'h09: begin
          cnt_sel_m <= o_gpio_to_regf[16];
          cnt_idx_m <= o_gpio_to_regf[2:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (cnt_idx_m)
      3'd0: lat_word = lat_err_i[31:0];
      3'd1: lat_word = lat_err_i[63:32];
      3'd2: lat_word = lat_bit_i[31:0];
      3'd3: lat_word = lat_bit_i[63:32];
      3'd4: lat_word = lat_err_q[31:0];
      3'd5: lat_word = lat_err_q[63:32];
      3'd6: lat_word = lat_bit_q[31:0];
      default: lat_word = lat_bit_q[63:32];
    endcase
    regf_to_gpio = 32'h0;
    if (ram_sel_m) regf_to_gpio = ram_word(ram_addr_m);
    else if (cnt_sel_m) regf_to_gpio = lat_word;
  end

  always @(posedge clk) begin
    if (!i_reset && i_req_valid && o_req_ready) accept_cnt <= accept_cnt + 1;
    if (o_rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  // Driver tasks
  task automatic send(input logic [1:0] op, input logic [7:0] cmd, input logic [22:0] data);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: ready=%b after %0d cycles, required 1", o_req_ready, n);
    end
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_cmd   = cmd;
    i_req_data  = data;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    i_req_op    = 2'($urandom_range(0, 3));
    i_req_cmd   = 8'($urandom_range(0, 255));
    i_req_data  = 23'($urandom_range(0, 8388607));
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!o_rsp_valid && cyc < 200);
  endtask

  // Scenarios
  task automatic test_reset();
    i_reset = 1'b1;
    i_req_valid = 1'b0;
    i_req_op = '0;
    i_req_cmd = '0;
    i_req_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_gpio_to_regf, o_rsp_valid, o_rsp_err, o_rsp_data, o_req_ready, o_busy} !== 67'h0) begin
      errors++;
      $display("FAIL reset_outputs: gpio=%h rv=%b re=%b rd=%h rdy=%b busy=%b, required all 0",
               o_gpio_to_regf, o_rsp_valid, o_rsp_err, o_rsp_data, o_req_ready, o_busy);
    end
    checks++;
    if ({o_accum_err_I, o_accum_bit_I, o_accum_err_Q, o_accum_bit_Q} !== 256'h0) begin
      errors++;
      $display("FAIL reset_accum: err_I=%h bit_I=%h, required 0", o_accum_err_I, o_accum_bit_I);
    end
    i_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after: got %b required 1", o_req_ready);
    end
  endtask

  task automatic test_write();
    int cyc;
    send(2'b00, 8'h03, 23'h00001C);
    @(negedge clk);
    checks++;
    if (o_gpio_to_regf !== 32'h0380001C || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL write_strobe1: gpio=%h busy=%b required 0380001C 1", o_gpio_to_regf, o_busy);
    end
    @(negedge clk);
    checks++;
    if (o_gpio_to_regf !== 32'h0380001C || o_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL write_strobe2: gpio=%h ready=%b required 0380001C 0", o_gpio_to_regf, o_req_ready);
    end
    @(negedge clk);
    checks++;
    if (o_gpio_to_regf !== 32'h0300001C) begin
      errors++;
      $display("FAIL write_gap: gpio=%h required 0300001C", o_gpio_to_regf);
    end
    @(negedge clk);
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b0 || o_gpio_to_regf !== 32'h0) begin
      errors++;
      $display("FAIL write_rsp: rv=%b re=%b gpio=%h required 1 0 0", o_rsp_valid, o_rsp_err, o_gpio_to_regf);
    end
    @(negedge clk);
    checks++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL write_idle: ready=%b rv=%b busy=%b required 1 0 0", o_req_ready, o_rsp_valid, o_busy);
    end
    checks++;
    if (sigma_m !== 23'h1C) begin
      errors++;
      $display("FAIL write_sigma: regf sigma=%h required 1C", sigma_m);
    end
    send(2'b00, 8'h02, 23'h7FFFFF);
    wait_rsp(cyc);
    checks++;
    if (o_rsp_valid !== 1'b1 || cyc != 4) begin
      errors++;
      $display("FAIL write2_latency: rsp=%b at cycle %0d required 1 at 4", o_rsp_valid, cyc);
    end
  endtask

  task automatic test_ram_read();
    int cyc;
    send(2'b01, 8'hFF, 23'h7F1234);
    @(negedge clk);
    checks++;
    if (o_gpio_to_regf !== 32'h07811234) begin
      errors++;
      $display("FAIL ram_rd_word: gpio=%h required 07811234", o_gpio_to_regf);
    end
    wait_rsp(cyc);
    cyc++;
    checks++;
    if (o_rsp_valid !== 1'b1 || cyc != 5) begin
      errors++;
      $display("FAIL ram_rd_latency: rsp=%b at cycle %0d required 1 at 5", o_rsp_valid, cyc);
    end
    checks++;
    if (o_rsp_data !== 32'hDEADBEEF || o_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL ram_rd_data: data=%h err=%b required DEADBEEF 0", o_rsp_data, o_rsp_err);
    end
  endtask

  task automatic test_snapshot();
    int cyc;
    cnt_err_i = 64'h1_00000002;
    cnt_bit_i = 64'h3_00000004;
    cnt_err_q = 64'h5;
    cnt_bit_q = 64'hFFFFFFFF_FFFFFFFF;
    send(2'b10, 8'h00, 23'h0);
    @(negedge clk);
    checks++;
    if (o_gpio_to_regf !== 32'h07800000) begin
      errors++;
      $display("FAIL snap_clr_ram: gpio=%h required 07800000", o_gpio_to_regf);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (o_gpio_to_regf !== 32'h08800001) begin
      errors++;
      $display("FAIL snap_latch_word: gpio=%h required 08800001", o_gpio_to_regf);
    end
    wait_rsp(cyc);
    cyc += 4;
    checks++;
    if (o_rsp_valid !== 1'b1 || cyc != 45) begin
      errors++;
      $display("FAIL snap_latency: rsp=%b at cycle %0d required 1 at 45", o_rsp_valid, cyc);
    end
    checks++;
    if (o_accum_err_I !== 64'h1_00000002 || o_accum_bit_I !== 64'h3_00000004) begin
      errors++;
      $display("FAIL snap_I: err_I=%h bit_I=%h required 0000000100000002 0000000300000004",
               o_accum_err_I, o_accum_bit_I);
    end
    checks++;
    if (o_accum_err_Q !== 64'h5 || o_accum_bit_Q !== 64'hFFFFFFFF_FFFFFFFF) begin
      errors++;
      $display("FAIL snap_Q: err_Q=%h bit_Q=%h required 5 FFFFFFFFFFFFFFFF", o_accum_err_Q, o_accum_bit_Q);
    end
    checks++;
    if (o_rsp_data !== 32'hDEADBEEF || o_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL snap_rsp_data_hold: data=%h err=%b required DEADBEEF 0", o_rsp_data, o_rsp_err);
    end
  endtask

  task automatic test_snapshot_stable();
    int cyc;
    cnt_err_i = 64'h11;
    cnt_bit_i = 64'h22;
    cnt_err_q = 64'h33;
    cnt_bit_q = 64'h44;
    send(2'b10, 8'h00, 23'h0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 15) begin
        cnt_err_i = 64'hAAAA;
        cnt_bit_i = 64'hBBBB;
        cnt_err_q = 64'hCCCC;
        cnt_bit_q = 64'hDDDD;
      end
      if (!o_rsp_valid) begin
        checks++;
        if (o_accum_err_I !== 64'h1_00000002 || o_accum_bit_Q !== 64'hFFFFFFFF_FFFFFFFF) begin
          errors++;
          $display("FAIL stable_before_rsp: cycle %0d err_I=%h bit_Q=%h required previous snapshot",
                   cyc, o_accum_err_I, o_accum_bit_Q);
        end
      end
    end while (!o_rsp_valid && cyc < 200);
    checks++;
    if (o_rsp_valid !== 1'b1 || cyc != 45) begin
      errors++;
      $display("FAIL stable_latency: rsp=%b at cycle %0d required 1 at 45", o_rsp_valid, cyc);
    end
    checks++;
    if (o_accum_err_I !== 64'h11 || o_accum_bit_I !== 64'h22 ||
        o_accum_err_Q !== 64'h33 || o_accum_bit_Q !== 64'h44) begin
      errors++;
      $display("FAIL stable_latched: %h %h %h %h required 11 22 33 44",
               o_accum_err_I, o_accum_bit_I, o_accum_err_Q, o_accum_bit_Q);
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    int rsp_before;
    send(2'b10, 8'h00, 23'h0);
    repeat (26) @(negedge clk);
    checks++;
    if (o_gpio_to_regf !== 32'h09810004) begin
      errors++;
      $display("FAIL midreset_idx4_word: gpio=%h required 09810004", o_gpio_to_regf);
    end
    i_reset = 1'b1;
    rsp_before = rsp_cnt;
    @(negedge clk);
    checks++;
    if (o_gpio_to_regf !== 32'h0 || o_rsp_valid !== 1'b0 || o_req_ready !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: gpio=%h rv=%b ready=%b busy=%b required 0 0 0 0",
               o_gpio_to_regf, o_rsp_valid, o_req_ready, o_busy);
    end
    checks++;
    if ({o_accum_err_I, o_accum_bit_I, o_accum_err_Q, o_accum_bit_Q} !== 256'h0) begin
      errors++;
      $display("FAIL midreset_accum: err_I=%h bit_I=%h required 0", o_accum_err_I, o_accum_bit_I);
    end
    i_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: got %b required 1", o_req_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_cnt != rsp_before) begin
      errors++;
      $display("FAIL midreset_no_rsp: rsp pulses=%0d required 0", rsp_cnt - rsp_before);
    end
    send(2'b00, 8'h01, 23'h000005);
    @(negedge clk);
    checks++;
    if (o_gpio_to_regf !== 32'h01800005) begin
      errors++;
      $display("FAIL midreset_write_word: gpio=%h required 01800005", o_gpio_to_regf);
    end
    wait_rsp(cyc);
    cyc++;
    checks++;
    if (o_rsp_valid !== 1'b1 || cyc != 4) begin
      errors++;
      $display("FAIL midreset_write_rsp: rsp=%b at cycle %0d required 1 at 4", o_rsp_valid, cyc);
    end
  endtask

  task automatic test_illegal_and_hold();
    int cyc;
    int acc_before;
    @(negedge clk);
    while (!o_req_ready) @(negedge clk);
    acc_before = accept_cnt;
    i_req_valid = 1'b1;
    i_req_op    = 2'b11;
    i_req_cmd   = 8'h06;
    i_req_data  = 23'h123;
    @(posedge clk);
    #1;
    i_req_op   = 2'b00;
    i_req_cmd  = 8'h04;
    i_req_data = 23'h00002A;
    @(negedge clk);
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b1 || o_gpio_to_regf !== 32'h0 || o_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL illegal_rsp: rv=%b re=%b gpio=%h ready=%b required 1 1 0 0",
               o_rsp_valid, o_rsp_err, o_gpio_to_regf, o_req_ready);
    end
    @(negedge clk);
    checks++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_idle: ready=%b rv=%b required 1 0", o_req_ready, o_rsp_valid);
    end
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_gpio_to_regf !== 32'h0480002A) begin
      errors++;
      $display("FAIL held_write_word: gpio=%h required 0480002A", o_gpio_to_regf);
    end
    wait_rsp(cyc);
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b0 || cyc != 3) begin
      errors++;
      $display("FAIL held_write_rsp: rv=%b re=%b at cycle %0d required 1 0 at 3", o_rsp_valid, o_rsp_err, cyc);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (accept_cnt - acc_before != 2) begin
      errors++;
      $display("FAIL held_accept_count: accepts=%0d required 2", accept_cnt - acc_before);
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_write();
    test_ram_read();
    test_snapshot();
    test_snapshot_stable();
    test_reset_mid_op();
    test_illegal_and_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
